// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state type, default widths and
// the per-program absolute jump target table.
package pc_sequencer_pkg;

  localparam int unsigned PcWDefault  = 10;
  localparam int unsigned IdxWDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } fetch_state_t;

  // Entries 8..15 are unprogrammed and return 0, so a bad index restarts at 0.
  localparam logic [PcWDefault-1:0] JUMP_TARGETS [2**IdxWDefault] = '{
    10'h100, 10'h3fe, 10'h3ff, 10'h020, 10'h005, 10'h009, 10'h00c, 10'h028,
    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000
  };

endpackage

// File: rtl/pc_sequencer_jump_lut.sv
// Combinational jump-target ROM indexed by the jump instruction's immediate.
module pc_sequencer_jump_lut
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W  = PcWDefault,
  parameter int unsigned IDX_W = IdxWDefault
) (
  input  logic [IDX_W-1:0] jump_idx,
  output logic [PC_W-1:0]  target
);

  assign target = PC_W'(JUMP_TARGETS[jump_idx]);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: run/halt/restart control plus the
// next-pc mux (halt > jump > compare-skip > fall-through).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W  = PcWDefault,
  parameter int unsigned IDX_W = IdxWDefault
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start,
  input  logic             branch_cmp,
  input  logic             branch_en,
  input  logic             jump_en,
  input  logic [IDX_W-1:0] jump_idx,
  input  logic             halt,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done
);

  fetch_state_t    state_q;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] pc_next;

  pc_sequencer_jump_lut #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_jump_lut (
    .jump_idx (jump_idx),
    .target   (jump_target)
  );

  // branch_en only matters for compare ops; jump beats a (bogus) concurrent compare.
  always_comb begin
    pc_next = pc + PC_W'(1);
    if (jump_en) begin
      pc_next = jump_target;
    end else if (branch_cmp && branch_en) begin
      pc_next = pc + PC_W'(2);
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pc <= '0;
          if (start) begin
            state_q <= StRun;
            running <= 1'b1;
          end
        end
        StRun: begin
          if (halt) begin
            state_q <= StHalt;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            pc <= pc_next;
          end
        end
        StHalt: begin
          if (start) begin
            state_q <= StRun;
            pc      <= '0;
            running <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          pc      <= '0;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_pc_sequencer;

  localparam int PcW   = 10;
  localparam int IdxW  = 4;
  localparam int Depth = 1 << PcW;

  logic            CLK;
  logic            reset_n;
  logic            start;
  logic            branch_cmp;
  logic            branch_en;
  logic            jump_en;
  logic [IdxW-1:0] jump_idx;
  logic            halt;
  logic [PcW-1:0]  pc;
  logic            running;
  logic            done;

  int checks;
  int errors;

  // Model: mode 0 = idle, 1 = run, 2 = halted.
  int m_mode;
  int m_pc;
  int m_lut [16];

  pc_sequencer #(
    .PC_W  (PcW),
    .IDX_W (IdxW)
  ) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .start      (start),
    .branch_cmp (branch_cmp),
    .branch_en  (branch_en),
    .jump_en    (jump_en),
    .jump_idx   (jump_idx),
    .halt       (halt),
    .pc         (pc),
    .running    (running),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_mode = 0;
      m_pc   = 0;
    end else if (m_mode == 0) begin
      m_pc = 0;
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (halt) m_mode = 2;
      else if (jump_en) m_pc = m_lut[int'(jump_idx)];
      else if (branch_cmp && branch_en) m_pc = (m_pc + 2) % Depth;
      else m_pc = (m_pc + 1) % Depth;
    end else begin
      if (start) begin
        m_mode = 1;
        m_pc   = 0;
      end
    end
  endtask

  // One clock: advance the model on the inputs present at the edge, then compare.
  task automatic cyc();
    model_step();
    @(posedge CLK);
    #1;
    check("pc", int'(pc), m_pc);
    check("running", int'(running), (m_mode == 1) ? 1 : 0);
    check("done", int'(done), (m_mode == 2) ? 1 : 0);
  endtask

  task automatic clear_flags();
    start      = 1'b0;
    branch_cmp = 1'b0;
    branch_en  = 1'b0;
    jump_en    = 1'b0;
    jump_idx   = '0;
    halt       = 1'b0;
  endtask

  task automatic jump_to(input int idx);
    clear_flags();
    jump_en  = 1'b1;
    jump_idx = IdxW'(idx);
    cyc();
    clear_flags();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_lut = '{32'h100, 32'h3fe, 32'h3ff, 32'h020, 32'h005, 32'h009, 32'h00c, 32'h028,
              0, 0, 0, 0, 0, 0, 0, 0};
    m_mode = 0;
    m_pc   = 0;
    clear_flags();
    reset_n = 1'b0;
    @(negedge CLK);

    // Reset for two cycles, with junk on start to show reset wins.
    start = 1'b1;
    cyc();
    cyc();
    check("rst_pc", int'(pc), 0);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);

    reset_n = 1'b1;
    cyc();
    check("launch_pc", int'(pc), 0);
    check("launch_running", int'(running), 1);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("step_pc", int'(pc), i);
    end

    jump_to(4);
    branch_cmp = 1'b1; branch_en = 1'b1;
    cyc();
    check("skip_pc", int'(pc), 7);
    jump_to(4);
    branch_cmp = 1'b1; branch_en = 1'b0;
    cyc();
    check("fall_pc", int'(pc), 6);
    jump_to(4);
    branch_cmp = 1'b0; branch_en = 1'b1;
    cyc();
    check("noncmp_pc", int'(pc), 6);

    jump_to(5);
    check("jump9_pc", int'(pc), 9);
    jump_en = 1'b1; jump_idx = 4'd3; branch_cmp = 1'b1; branch_en = 1'b1;
    cyc();
    check("jump_prio_pc", int'(pc), 32'h020);

    jump_to(2);
    cyc();
    check("wrap1_pc", int'(pc), 0);
    jump_to(1);
    branch_cmp = 1'b1; branch_en = 1'b1;
    cyc();
    check("wrap2a_pc", int'(pc), 0);
    jump_to(2);
    branch_cmp = 1'b1; branch_en = 1'b1;
    cyc();
    check("wrap2b_pc", int'(pc), 1);

    jump_to(6);
    halt = 1'b1;
    cyc();
    clear_flags();
    for (int i = 0; i < 5; i++) begin
      jump_en = i[0];
      jump_idx = 4'd3;
      cyc();
      check("halt_pc", int'(pc), 12);
      check("halt_done", int'(done), 1);
      check("halt_running", int'(running), 0);
    end
    clear_flags();
    start = 1'b1;
    cyc();
    check("restart_pc", int'(pc), 0);
    check("restart_done", int'(done), 0);
    check("restart_running", int'(running), 1);
    start = 1'b0;

    jump_to(7);
    check("pc40", int'(pc), 40);
    reset_n = 1'b0;
    cyc();
    check("midrst_pc", int'(pc), 0);
    check("midrst_running", int'(running), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle_pc", int'(pc), 0);
      check("idle_running", int'(running), 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n    = ($urandom_range(0, 63) != 0);
      start      = ($urandom_range(0, 15) == 0);
      halt       = ($urandom_range(0, 19) == 0);
      jump_en    = ($urandom_range(0, 5) == 0);
      jump_idx   = IdxW'($urandom_range(0, 15));
      branch_cmp = ($urandom_range(0, 2) == 0);
      branch_en  = $urandom_range(0, 1) == 1;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
